// File: rtl/acc_out_stream_packer_if.sv
//------------------------------------------------------------------------------
// acc_result_if / axis128_if : accelerator result port and 128-bit AXI4-Stream
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface acc_result_if;
   logic         in_valid;
   logic [127:0] in_data;
   logic         in_last;
   logic         full_out;

   modport master (output in_valid, output in_data, output in_last, input full_out);
   modport slave  (input in_valid, input in_data, input in_last, output full_out);
endinterface

interface axis128_if;
   logic [127:0] tdata;
   logic         tvalid;
   logic         tready;
   logic         tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/acc_out_stream_packer.sv
//------------------------------------------------------------------------------
// acc_out_stream_packer : FIFO + AXI4-Stream master for AES/CTR result words
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module acc_out_stream_packer #(
   parameter int DEPTH     = 8,
   parameter int AF_MARGIN = 4
) (
   input  logic        clk,
   input  logic        reset,
   acc_result_if.slave res,
   axis128_if.master   m_axis,
   output logic [31:0] frame_beats,
   output logic        frame_done,
   output logic        overflow
);

   localparam int              c_AW       = $clog2(DEPTH);
   localparam logic [c_AW:0]   c_DEPTH    = (c_AW+1)'(DEPTH);
   localparam logic [c_AW:0]   c_AF_LEVEL = (c_AW+1)'(DEPTH - AF_MARGIN);
   localparam logic [c_AW:0]   c_CNT_ONE  = (c_AW+1)'(1);
   localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACTIVE  = 2'd1,
      S_CLOSING = 2'd2
   } state_t;

   logic [127:0]    r_mem_data [DEPTH];
   logic [DEPTH-1:0] r_mem_last;
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_AW:0]   r_count;
   logic [c_AW:0]   r_last_cnt;
   logic            r_full;
   logic            r_overflow;
   logic            r_frame_done;
   logic [31:0]     r_frame_beats;
   logic [31:0]     r_beat_cnt;
   state_t          r_state;
   state_t          w_state_next;

   logic            w_tvalid;
   logic            w_pop;
   logic            w_push;
   logic            w_drop;
   logic            w_head_last;
   logic [c_AW-1:0] w_tail_ptr;
   logic            w_mark_req;
   logic            w_tail_popping;
   logic            w_mark_tail;
   logic            w_close_empty;
   logic            w_close_beat;
   logic [c_AW:0]   w_count_next;
   logic [c_AW:0]   w_last_cnt_next;
   logic [31:0]     w_beat_inc;

   assign w_tvalid       = (r_count != '0);
   assign w_head_last    = r_mem_last[r_rd_ptr];
   assign w_pop          = w_tvalid & m_axis.tready;
   assign w_push         = res.in_valid & ((r_count != c_DEPTH) | w_pop);
   assign w_drop         = res.in_valid & ~w_push;
   assign w_tail_ptr     = r_wr_ptr - c_PTR_ONE;
   assign w_mark_req     = res.in_last & ~res.in_valid;
   // A lone in_last arriving as the only buffered word leaves closes the frame with that word
   assign w_tail_popping = (r_count == c_CNT_ONE) & w_pop;
   assign w_mark_tail    = w_mark_req & w_tvalid & ~w_tail_popping;
   assign w_close_empty  = w_mark_req & (~w_tvalid | (w_tail_popping & ~w_head_last));
   assign w_close_beat   = w_pop & w_head_last;

   assign w_count_next    = r_count + (c_AW+1)'(w_push) - (c_AW+1)'(w_pop);
   assign w_last_cnt_next = r_last_cnt
                          + (c_AW+1)'(w_push & res.in_last)
                          + (c_AW+1)'(w_mark_tail & ~r_mem_last[w_tail_ptr])
                          - (c_AW+1)'(w_close_beat);
   assign w_beat_inc      = (r_beat_cnt == 32'hFFFF_FFFF) ? r_beat_cnt : r_beat_cnt + 32'd1;

   assign m_axis.tvalid = w_tvalid;
   assign m_axis.tdata  = w_tvalid ? r_mem_data[r_rd_ptr] : '0;
   assign m_axis.tlast  = w_tvalid & w_head_last;
   assign res.full_out  = r_full;
   assign frame_beats   = r_frame_beats;
   assign frame_done    = r_frame_done;
   assign overflow      = r_overflow;

   always_ff @(posedge clk) begin : p_mem_data
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= res.in_data;
      end
   end

   always_ff @(posedge clk) begin : p_fifo
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_last_cnt <= '0;
         r_mem_last <= '0;
         r_full     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr             <= r_wr_ptr + c_PTR_ONE;
            r_mem_last[r_wr_ptr] <= res.in_last;
         end else if (w_mark_tail) begin
            r_mem_last[w_tail_ptr] <= 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         r_count    <= w_count_next;
         r_last_cnt <= w_last_cnt_next;
         r_full     <= (w_count_next >= c_AF_LEVEL);
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin : p_beats
      if (!reset) begin
         r_beat_cnt    <= '0;
         r_frame_beats <= '0;
         r_frame_done  <= 1'b0;
      end else begin
         r_frame_done <= w_close_beat | w_close_empty;
         if (w_close_beat | (w_close_empty & w_pop)) begin
            r_frame_beats <= w_beat_inc;
            r_beat_cnt    <= '0;
         end else if (w_close_empty) begin
            r_frame_beats <= r_beat_cnt;
            r_beat_cnt    <= '0;
         end else if (w_pop) begin
            r_beat_cnt <= w_beat_inc;
         end
      end
   end

   always_ff @(posedge clk) begin : p_state
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin : p_state_next
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_push) begin
               w_state_next = res.in_last ? S_CLOSING : S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if ((w_push & res.in_last) | w_mark_tail) begin
               w_state_next = S_CLOSING;
            end else if (w_close_empty) begin
               w_state_next = S_IDLE;
            end
         end
         S_CLOSING: begin
            // Another complete frame may already be queued behind the one closing
            if (w_close_beat) begin
               if (w_last_cnt_next != '0) begin
                  w_state_next = S_CLOSING;
               end else if (w_count_next != '0) begin
                  w_state_next = S_ACTIVE;
               end else begin
                  w_state_next = S_IDLE;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

endmodule

`default_nettype wire
